// File: rtl/max7219_rx_pkg.sv
// Shared constants for the MAX7219-style serial receiver: frame geometry,
// register addresses and frame FSM encoding.
package max7219_rx_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_W      = 5;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/max7219_rx_sync.sv
// Multi-flop synchronizer with a history flop and rising-edge detect.
module sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic rise_c
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chain <= {STAGES{RESET_VAL}};
            hist  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            hist  <= chain[STAGES-1];
        end
    end

    assign q      = chain[STAGES-1];
    assign rise_c = q & ~hist;

endmodule

// File: rtl/max7219_rx.sv
// Receives 16-bit MAX7219 frames on a 3-wire serial port and maintains the
// chip's register file; one wr_valid pulse per committed frame.
module max7219_rx
    import max7219_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        di_ncs,
    input  logic        di_dta,
    input  logic        di_cks,
    output logic        wr_valid,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [63:0] digits,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic        frame_err
);

    logic                   ncs_s, ncs_rise, cks_rise, dta_s;
    logic                   unused_cks_level;
    logic [SYNC_STAGES-1:0] dta_chain;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [15:0]            sr, sr_nxt;
    logic                   commit_c, err_c;
    logic [3:0]             addr_c;
    logic [7:0]             data_c;
    logic [2:0]             dig_sel;

    // ncs idles high so its chain resets high; no phantom edge after reset
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (di_ncs),
        .q      (ncs_s),
        .rise_c (ncs_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cks_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (di_cks),
        .q      (unused_cks_level),
        .rise_c (cks_rise)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) dta_chain <= '0;
        else         dta_chain <= {dta_chain[SYNC_STAGES-2:0], di_dta};
    end
    assign dta_s = dta_chain[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!ncs_s)   state_nxt = ST_SHIFT;
            ST_SHIFT: if (ncs_rise) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Previous ncs is always low while in SHIFT, so a cks rise in the
    // ncs_rise cycle still shifts and is part of the committed frame.
    always_comb begin
        cnt_nxt  = cnt;
        sr_nxt   = sr;
        commit_c = 1'b0;
        err_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ncs_s) begin
                    cnt_nxt = '0;
                    sr_nxt  = '0;
                end
            end
            ST_SHIFT: begin
                if (cks_rise) begin
                    sr_nxt = {sr[14:0], dta_s};
                    if (cnt != CNT_W'(FRAME_BITS)) cnt_nxt = cnt + CNT_W'(1);
                end
                if (ncs_rise) begin
                    if (cnt_nxt == CNT_W'(FRAME_BITS)) commit_c = 1'b1;
                    else                               err_c    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            sr  <= '0;
        end else begin
            cnt <= cnt_nxt;
            sr  <= sr_nxt;
        end
    end

    assign addr_c  = sr_nxt[11:8];
    assign data_c  = sr_nxt[7:0];
    assign dig_sel = 3'(addr_c - ADDR_DIGIT0);

    // Register file update, visible in the same cycle as wr_valid
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_valid     <= 1'b0;
            frame_err    <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            digits       <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
        end else begin
            wr_valid  <= commit_c;
            frame_err <= err_c;
            if (commit_c) begin
                wr_addr <= addr_c;
                wr_data <= data_c;
                case (addr_c)
                    ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                    ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                        digits[{dig_sel, 3'b000} +: 8] <= data_c;
                    ADDR_DECODE:    decode_mode  <= data_c;
                    ADDR_INTENSITY: intensity    <= data_c[3:0];
                    ADDR_SCANLIMIT: scan_limit   <= data_c[2:0];
                    ADDR_SHUTDOWN:  shutdown_n   <= data_c[0];
                    ADDR_TEST:      display_test <= data_c[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_max7219_rx.sv
// Self-checking bench for max7219_rx: vector table, hand sequences for
// reset/alignment corners, and random frames against a register-file model.
module tb_max7219_rx;

    localparam int unsigned S = 2;

    logic        clk, resetn, di_ncs, di_dta, di_cks;
    logic        wr_valid, frame_err, shutdown_n, display_test;
    logic [3:0]  wr_addr, intensity;
    logic [7:0]  wr_data, decode_mode;
    logic [63:0] digits;
    logic [2:0]  scan_limit;

    max7219_rx #(.SYNC_STAGES(S)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .di_ncs       (di_ncs),
        .di_dta       (di_dta),
        .di_cks       (di_cks),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .digits       (digits),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown_n   (shutdown_n),
        .display_test (display_test),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [3:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (wr_valid === 1'b1) begin
                n_valid++;
                last_addr = wr_addr;
                last_data = wr_data;
            end
            if (frame_err === 1'b1) n_err++;
        end
    end

    // Reference register file
    logic [7:0] m_dig [8];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shdn, m_test;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = '0;
        m_decode = '0; m_int = '0; m_scan = '0; m_shdn = 1'b0; m_test = 1'b0;
    endtask

    task automatic model_frame(input logic [31:0] bits, input int n);
        logic [15:0] f;
        int a;
        if (n < 16) return;
        f = bits[15:0];
        a = int'(f[11:8]);
        if (a >= 1 && a <= 8) m_dig[a-1] = f[7:0];
        else if (a == 9)  m_decode = f[7:0];
        else if (a == 10) m_int    = f[3:0];
        else if (a == 11) m_scan   = f[2:0];
        else if (a == 12) m_shdn   = f[0];
        else if (a == 15) m_test   = f[0];
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [63:0] e;
        for (int i = 0; i < 8; i++) e[8*i +: 8] = m_dig[i];
        check({tag, "/digits"},       digits,              e);
        check({tag, "/decode_mode"},  64'(decode_mode),    64'(m_decode));
        check({tag, "/intensity"},    64'(intensity),      64'(m_int));
        check({tag, "/scan_limit"},   64'(scan_limit),     64'(m_scan));
        check({tag, "/shutdown_n"},   64'(shutdown_n),     64'(m_shdn));
        check({tag, "/display_test"}, 64'(display_test),   64'(m_test));
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b, input bit raise_ncs);
        di_dta = b;
        clks(4);
        di_cks = 1'b1;
        if (raise_ncs) di_ncs = 1'b1;
        clks(4);
        di_cks = 1'b0;
    endtask

    // lat = negedge index (after the ncs rise) at which a result pulse shows
    task automatic end_frame(output int lat);
        clks(2);
        di_ncs = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (lat == 0 && (wr_valid === 1'b1 || frame_err === 1'b1)) lat = k;
        end
        clks(4);
    endtask

    task automatic run_frame(input logic [31:0] bits, input int n, output int lat);
        di_ncs = 1'b0;
        clks(3);
        for (int i = n - 1; i >= 0; i--) shift_bit(bits[i], 1'b0);
        end_frame(lat);
        model_frame(bits, n);
    endtask

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          exp_valid;
        int          exp_err;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vt[$];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0, e0, lat;
        logic [31:0] rb;
        int rn;

        resetn = 1'b0; di_ncs = 1'b1; di_dta = 1'b0; di_cks = 1'b0;
        model_reset();
        clks(3);
        check("reset/wr_valid",  64'(wr_valid),  64'(0));
        check("reset/frame_err", 64'(frame_err), 64'(0));
        check("reset/wr_addr",   64'(wr_addr),   64'(0));
        check("reset/wr_data",   64'(wr_data),   64'(0));
        check_regs("reset");
        resetn = 1'b1;
        clks(6);
        check("idle/no_pulses", 64'(n_valid + n_err), 64'(0));

        vt.push_back('{32'h0C01,   16, 1, 0, 4'hC, 8'h01});
        vt.push_back('{32'h0A00,   16, 1, 0, 4'hA, 8'h00});
        vt.push_back('{32'h0B07,   16, 1, 0, 4'hB, 8'h07});
        vt.push_back('{32'hFF00,   16, 1, 0, 4'hF, 8'h00});
        vt.push_back('{32'h017E,   16, 1, 0, 4'h1, 8'h7E});
        vt.push_back('{32'h0212,   16, 1, 0, 4'h2, 8'h12});
        vt.push_back('{32'h0334,   16, 1, 0, 4'h3, 8'h34});
        vt.push_back('{32'h0456,   16, 1, 0, 4'h4, 8'h56});
        vt.push_back('{32'h0578,   16, 1, 0, 4'h5, 8'h78});
        vt.push_back('{32'h069A,   16, 1, 0, 4'h6, 8'h9A});
        vt.push_back('{32'h07BC,   16, 1, 0, 4'h7, 8'hBC});
        vt.push_back('{32'h0847,   16, 1, 0, 4'h8, 8'h47});
        vt.push_back('{32'h00C1,   12, 0, 1, 4'h0, 8'h00});
        vt.push_back('{32'hF0305,  20, 1, 0, 4'h3, 8'h05});
        vt.push_back('{32'h0,       0, 0, 1, 4'h0, 8'h00});
        vt.push_back('{32'h0955,   16, 1, 0, 4'h9, 8'h55});
        vt.push_back('{32'h0D33,   16, 1, 0, 4'hD, 8'h33});
        vt.push_back('{32'h0E11,   16, 1, 0, 4'hE, 8'h11});
        vt.push_back('{32'h0000,   16, 1, 0, 4'h0, 8'h00});
        vt.push_back('{32'h0F01,   16, 1, 0, 4'hF, 8'h01});

        for (int i = 0; i < vt.size(); i++) begin
            v0 = n_valid; e0 = n_err;
            run_frame(vt[i].bits, vt[i].nbits, lat);
            check($sformatf("vec%0d/valid_cnt", i), 64'(n_valid - v0), 64'(vt[i].exp_valid));
            check($sformatf("vec%0d/err_cnt", i),   64'(n_err - e0),   64'(vt[i].exp_err));
            check($sformatf("vec%0d/latency", i),   64'(lat),          64'(S + 2));
            if (vt[i].exp_valid != 0) begin
                check($sformatf("vec%0d/wr_addr", i), 64'(last_addr), 64'(vt[i].exp_addr));
                check($sformatf("vec%0d/wr_data", i), 64'(last_data), 64'(vt[i].exp_data));
            end
            check_regs($sformatf("vec%0d", i));
            if (i == 11)
                check("seq12/digits", digits, 64'h47BC_9A78_5634_127E);
        end

        // Final cks rise lands with the ncs rise
        v0 = n_valid;
        di_ncs = 1'b0;
        clks(3);
        rb = 32'h0201;
        for (int i = 15; i >= 1; i--) shift_bit(rb[i], 1'b0);
        shift_bit(rb[0], 1'b1);
        clks(12);
        model_frame(rb, 16);
        check("aligned/valid_cnt", 64'(n_valid - v0), 64'(1));
        check("aligned/wr_data",   64'(last_data),    64'(8'h01));
        check_regs("aligned");

        // cks activity with ncs high is ignored
        v0 = n_valid; e0 = n_err;
        for (int k = 0; k < 6; k++) shift_bit(k[0], 1'b0);
        clks(8);
        check("ncs_high/pulses", 64'(n_valid - v0 + n_err - e0), 64'(0));
        check_regs("ncs_high");

        // Reset after 8 bits discards the partial frame
        v0 = n_valid; e0 = n_err;
        di_ncs = 1'b0;
        clks(3);
        rb = 32'h0412;
        for (int i = 15; i >= 8; i--) shift_bit(rb[i], 1'b0);
        resetn = 1'b0;
        model_reset();
        clks(3);
        check("rst_mid/wr_valid", 64'(wr_valid), 64'(0));
        check_regs("rst_mid");
        resetn = 1'b1;
        clks(3);
        end_frame(lat);
        check("rst_mid/valid_cnt", 64'(n_valid - v0), 64'(0));
        check("rst_mid/err_cnt",   64'(n_err - e0),   64'(1));
        check("rst_mid/digit4",    64'(digits[31:24]), 64'(0));

        // Frame in progress across reset is received from the next bit
        v0 = n_valid;
        di_ncs = 1'b0;
        clks(3);
        for (int i = 0; i < 5; i++) shift_bit(1'b1, 1'b0);
        resetn = 1'b0;
        model_reset();
        clks(2);
        resetn = 1'b1;
        clks(2);
        rb = 32'h0599;
        for (int i = 15; i >= 0; i--) shift_bit(rb[i], 1'b0);
        end_frame(lat);
        model_frame(rb, 16);
        check("rst_resume/valid_cnt", 64'(n_valid - v0), 64'(1));
        check("rst_resume/wr_addr",   64'(last_addr),    64'(4'h5));
        check_regs("rst_resume");

        // Random frames of 10..20 bits
        for (int i = 0; i < 40; i++) begin
            rb = $urandom;
            rn = int'($urandom_range(20, 10));
            v0 = n_valid; e0 = n_err;
            run_frame(rb, rn, lat);
            check($sformatf("rnd%0d/valid_cnt", i), 64'(n_valid - v0), 64'((rn >= 16) ? 1 : 0));
            check($sformatf("rnd%0d/err_cnt", i),   64'(n_err - e0),   64'((rn >= 16) ? 0 : 1));
            if (rn >= 16) begin
                check($sformatf("rnd%0d/wr_addr", i), 64'(last_addr), 64'(rb[11:8]));
                check($sformatf("rnd%0d/wr_data", i), 64'(last_data), 64'(rb[7:0]));
            end
            check_regs($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
